// File: rtl/rally_referee.sv
// Volleyball rally referee: tracks touches per side, detects touch-limit faults
// and ground hits, scores points, rotates serve and times the post-point pause.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   gnd_col, xposball         ground contact and ball x position
//   col_p1, col_p2            player/ball collisions
//   score_p1, score_p2        saturating scores
//   touches_p1, touches_p2    consecutive touches per side (saturating, 3 bits)
//   server                    0: player 1 serves, 1: player 2 serves
//   point_valid, point_winner one-cycle point pulse and winner of last point
//   fault                     pulses with point_valid for touch-limit points
//   endgame, winner           game-over level and game winner
module rally_referee #(
    parameter int unsigned WIN_SCORE   = 15,
    parameter int unsigned WIN_BY_TWO  = 1,
    parameter int unsigned MAX_TOUCHES = 3,
    parameter int unsigned NET_LEFT    = 500,
    parameter int unsigned NET_RIGHT   = 523,
    parameter int unsigned TOUCH_GAP   = 16_250_000,
    parameter int unsigned POINT_PAUSE = 195_000_000,
    parameter int unsigned SCORE_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gnd_col,
    input  logic [11:0]        xposball,
    input  logic               col_p1,
    input  logic               col_p2,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [2:0]         touches_p1,
    output logic [2:0]         touches_p2,
    output logic               server,
    output logic               point_valid,
    output logic               point_winner,
    output logic               fault,
    output logic               endgame,
    output logic               winner
);

    localparam int unsigned LOCK_W     = (TOUCH_GAP > 0) ? $clog2(TOUCH_GAP + 1) : 1;
    localparam int unsigned PAUSE_W    = (POINT_PAUSE > 1) ? $clog2(POINT_PAUSE) : 1;
    localparam int unsigned PAUSE_LAST = (POINT_PAUSE > 0) ? POINT_PAUSE - 1 : 0;
    localparam int unsigned SW1        = SCORE_W + 1;
    localparam int unsigned FAULT_AT   = MAX_TOUCHES + 1;

    typedef enum logic [2:0] {ST_SERVE, ST_RALLY, ST_POINT, ST_PAUSE, ST_END} state_e;

    state_e              state_q, state_d;
    logic [SCORE_W-1:0]  score1_q, score1_d, score2_q, score2_d;
    logic [2:0]          t1_q, t1_d, t2_q, t2_d;
    logic                server_q, server_d;
    logic                pv_q, pv_d, pw_q, pw_d, fault_q, fault_d;
    logic                endgame_q, endgame_d, winner_q, winner_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [PAUSE_W-1:0]  pause_q, pause_d;
    logic                last_q, last_d;      // last accepted toucher
    logic                loser_q, loser_d;    // loser of the pending point
    logic                fpend_q, fpend_d;    // pending point came from touch limit

    logic                side_p1_c, side_p2_c, any_col_c, toucher_c, game_over_c;
    logic [2:0]          tnew_c;
    logic [SCORE_W:0]    win_s_c, lose_s_c;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + SCORE_W'(1);
    endfunction

    // Ball side, toucher resolution (simultaneous hits go by ball side, net zone to server)
    always_comb begin
        side_p1_c = (xposball < 12'(NET_LEFT));
        side_p2_c = (xposball > 12'(NET_RIGHT));
        any_col_c = col_p1 | col_p2;
        toucher_c = col_p2;
        if (col_p1 && col_p2) begin
            toucher_c = side_p1_c ? 1'b0 : (side_p2_c ? 1'b1 : server_q);
        end
    end

    // Game-over test on the scores after the last point
    always_comb begin
        win_s_c     = pw_q ? {1'b0, score2_q} : {1'b0, score1_q};
        lose_s_c    = pw_q ? {1'b0, score1_q} : {1'b0, score2_q};
        game_over_c = (win_s_c >= SW1'(WIN_SCORE)) &&
                      ((WIN_BY_TWO == 0) ||
                       ((win_s_c >= lose_s_c) && ((win_s_c - lose_s_c) >= SW1'(2))));
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        score1_d  = score1_q;
        score2_d  = score2_q;
        t1_d      = t1_q;
        t2_d      = t2_q;
        server_d  = server_q;
        pv_d      = 1'b0;
        pw_d      = pw_q;
        fault_d   = 1'b0;
        endgame_d = endgame_q;
        winner_d  = winner_q;
        lock_d    = (lock_q != '0) ? lock_q - LOCK_W'(1) : lock_q;
        pause_d   = pause_q;
        last_d    = last_q;
        loser_d   = loser_q;
        fpend_d   = fpend_q;
        tnew_c    = 3'd0;

        unique case (state_q)
            ST_SERVE: begin
                t1_d = 3'd0;
                t2_d = 3'd0;
                if (any_col_c) begin
                    state_d = ST_RALLY;
                    last_d  = toucher_c;
                    lock_d  = LOCK_W'(TOUCH_GAP);
                    if (toucher_c) t2_d = 3'd1;
                    else           t1_d = 3'd1;
                end
            end
            ST_RALLY: begin
                // Ground contact outranks any touch in the same cycle
                if (gnd_col) begin
                    state_d = ST_POINT;
                    fpend_d = 1'b0;
                    loser_d = side_p1_c ? 1'b0 : (side_p2_c ? 1'b1 : last_q);
                end else if (any_col_c && (lock_q == '0)) begin
                    last_d = toucher_c;
                    lock_d = LOCK_W'(TOUCH_GAP);
                    tnew_c = sat_inc3(toucher_c ? t2_q : t1_q);
                    if (toucher_c) begin
                        t2_d = tnew_c;
                        t1_d = 3'd0;
                    end else begin
                        t1_d = tnew_c;
                        t2_d = 3'd0;
                    end
                    if (32'(tnew_c) == FAULT_AT) begin
                        state_d = ST_POINT;
                        loser_d = toucher_c;
                        fpend_d = 1'b1;
                    end
                end
            end
            ST_POINT: begin
                state_d  = ST_PAUSE;
                pause_d  = '0;
                lock_d   = '0;
                pv_d     = 1'b1;
                fault_d  = fpend_q;
                pw_d     = ~loser_q;
                server_d = ~loser_q;
                if (loser_q) score1_d = sat_inc_score(score1_q);
                else         score2_d = sat_inc_score(score2_q);
            end
            ST_PAUSE: begin
                if (pause_q == PAUSE_W'(PAUSE_LAST)) begin
                    if (game_over_c) begin
                        state_d   = ST_END;
                        endgame_d = 1'b1;
                        winner_d  = pw_q;
                    end else begin
                        state_d = ST_SERVE;
                        t1_d    = 3'd0;
                        t2_d    = 3'd0;
                    end
                end else begin
                    pause_d = pause_q + PAUSE_W'(1);
                end
            end
            ST_END: begin
            end
            default: state_d = ST_SERVE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SERVE;
            score1_q  <= '0;
            score2_q  <= '0;
            t1_q      <= 3'd0;
            t2_q      <= 3'd0;
            server_q  <= 1'b0;
            pv_q      <= 1'b0;
            pw_q      <= 1'b0;
            fault_q   <= 1'b0;
            endgame_q <= 1'b0;
            winner_q  <= 1'b0;
            lock_q    <= '0;
            pause_q   <= '0;
            last_q    <= 1'b0;
            loser_q   <= 1'b0;
            fpend_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            server_q  <= server_d;
            pv_q      <= pv_d;
            pw_q      <= pw_d;
            fault_q   <= fault_d;
            endgame_q <= endgame_d;
            winner_q  <= winner_d;
            lock_q    <= lock_d;
            pause_q   <= pause_d;
            last_q    <= last_d;
            loser_q   <= loser_d;
            fpend_q   <= fpend_d;
        end
    end

    assign score_p1     = score1_q;
    assign score_p2     = score2_q;
    assign touches_p1   = t1_q;
    assign touches_p2   = t2_q;
    assign server       = server_q;
    assign point_valid  = pv_q;
    assign point_winner = pw_q;
    assign fault        = fault_q;
    assign endgame      = endgame_q;
    assign winner       = winner_q;

endmodule
